// File: rtl/mult_div_pkg.sv
// Shared types and constants for the mult_div iterative signed multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;
  localparam int   ITER_COUNT = 32;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, 32 steps per operation.
// Optional macro MULT_DIV_DIV0_CHECK_EN short-circuits divide-by-zero with a div0 pulse.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

`ifdef MULT_DIV_DIV0_CHECK_EN
  localparam logic DIV0_CHK = 1'b1;
`else
  localparam logic DIV0_CHK = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [31:0] m_q, m_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

  logic [32:0] m_ext_s, booth_sum_s, booth_acc_s, rem_sh_s, diff_s, div_acc_s;
  logic [31:0] booth_q_s, div_q_s;
  logic        div_ok_s, last_s;

  // One Booth step and one restoring-division step, computed every cycle from the working registers
  always_comb begin
    m_ext_s = {m_q[31], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum_s = acc_q + m_ext_s;
      2'b10:   booth_sum_s = acc_q - m_ext_s;
      default: booth_sum_s = acc_q;
    endcase
    booth_acc_s = {booth_sum_s[32], booth_sum_s[32:1]};
    booth_q_s   = {booth_sum_s[0], q_q[31:1]};
    rem_sh_s    = {acc_q[31:0], q_q[31]};
    diff_s      = rem_sh_s - {1'b0, m_q};
    div_ok_s    = ~diff_s[32];
    div_acc_s   = div_ok_s ? diff_s : rem_sh_s;
    div_q_s     = {q_q[30:0], div_ok_s};
    last_s      = (cnt_q == 6'(ITER_COUNT - 1));
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = 6'd0;
          acc_d = 33'd0;
          qm1_d = 1'b0;
          if (op == OP_MULT) begin
            q_d     = a;
            m_d     = b;
            state_d = MULT;
          end else if (DIV0_CHK && (b == 32'd0)) begin
            state_d = DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else begin
            // Divide on magnitudes; signs are re-applied on the final step
            q_d     = a[31] ? neg32(a) : a;
            m_d     = b[31] ? neg32(b) : b;
            qneg_d  = a[31] ^ b[31];
            rneg_d  = a[31];
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d = booth_acc_s;
        q_d   = booth_q_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 6'd1;
        if (last_s) begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = booth_acc_s[31:0];
          lo_d    = booth_q_s;
          cnt_d   = 6'd0;
        end else begin
          state_d = MULT;
        end
      end
      DIV: begin
        acc_d = div_acc_s;
        q_d   = div_q_s;
        cnt_d = cnt_q + 6'd1;
        if (last_s) begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = rneg_q ? neg32(div_acc_s[31:0]) : div_acc_s[31:0];
          lo_d    = qneg_q ? neg32(div_q_s) : div_q_s;
          cnt_d   = 6'd0;
        end else begin
          state_d = DIV;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MULT) || (state_d == DIV);
  end

  // State and result registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 33'd0;
      q_q     <= 32'd0;
      qm1_q   <= 1'b0;
      m_q     <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed vector table, corner sequences and randomized ops vs. an arithmetic model.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mult_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ed0, output int lat);
    longint sx, sy, p, qq, rr;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ed0 = 1'b0;
    lat = 33;
    if (o == 1'b0) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'd0) begin
`ifdef MULT_DIV_DIV0_CHECK_EN
      eh  = model_hi;
      el  = model_lo;
      ed0 = 1'b1;
      lat = 1;
`else
      eh = x;
      el = x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      eh = rr[31:0];
      el = qq[31:0];
    end
  endtask

  // Issue one op and watch up to 45 cycles; inj>0 pulses a stray start at cycle T+inj
  task automatic run_op(input string name, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input int inj);
    logic [31:0] eh, el, got_hi, got_lo;
    logic        ed0, got_d0;
    int          lat, done_at, dones, busy_bad, interm, d0_stray;
    model(o, x, y, eh, el, ed0, lat);
    done_at = 0; dones = 0; busy_bad = 0; interm = 0; d0_stray = 0;
    got_hi = 32'd0; got_lo = 32'd0; got_d0 = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    for (int n = 1; n <= 45; n++) begin
      if (done) begin
        dones++;
        if (done_at == 0) begin
          done_at = n; got_hi = hi; got_lo = lo; got_d0 = div0;
        end
      end else if (div0) begin
        d0_stray++;
      end
      if (busy !== (n < lat)) busy_bad++;
      if (done_at == 0 && (hi !== model_hi || lo !== model_lo)) interm++;
      start = (n == inj);
      if (n == inj) begin
        op = $urandom; a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " latency"}, 64'(done_at), 64'(lat));
    check({name, " done_count"}, 64'(dones), 64'd1);
    check({name, " hi"}, {32'd0, got_hi}, {32'd0, eh});
    check({name, " lo"}, {32'd0, got_lo}, {32'd0, el});
    check({name, " div0"}, {63'd0, got_d0}, {63'd0, ed0});
    check({name, " busy_window"}, 64'(busy_bad), 64'd0);
    check({name, " hold_until_done"}, 64'(interm + d0_stray), 64'd0);
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    logic [31:0] pick[6];
    int bad;
    vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14};
    vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[6] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2};
    vecs[7] = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

    reset = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div0}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_flags", {61'd0, busy, done, div0}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] eh, el;
      logic        ed0;
      int          lat;
      model(vecs[i].op, vecs[i].a, vecs[i].b, eh, el, ed0, lat);
      check($sformatf("vec%0d table_vs_model", i), {eh, el}, {vecs[i].exp_hi, vecs[i].exp_lo});
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0);
    end

    run_op("div100by0", 1'b1, 32'd100, 32'd0, 0);
    run_op("negdiv_by0", 1'b1, 32'hFFFF_FF00, 32'd0, 0);

    run_op("start_while_busy", 1'b0, 32'h0001_2345, 32'hFFFF_0F0F, 5);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd1234; b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midop_reset_data", {hi, lo}, 64'd0);
    check("midop_reset_flags", {61'd0, busy, done, div0}, 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy || div0) bad++;
      @(negedge clk);
    end
    check("no_done_after_abort", 64'(bad), 64'd0);
    run_op("mult3x4", 1'b0, 32'd3, 32'd4, 0);

    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      pick[5] = $urandom;
      x = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), x, y, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have port: start  input  1  request strobe, sampled only in IDLE.
REQ-004 SHALL have port: op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-005 SHALL have port: a  input  32  multiplicand or dividend (register A value).
REQ-006 SHALL have port: b  input  32  multiplier or divisor (register B value).
REQ-007 SHALL have port: hi  output  32  product[63:32] or remainder; feeds HI register.
REQ-008 SHALL have port: lo  output  32  product[31:0] or quotient; feeds LO register.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; hi/lo valid in that cycle (HI/LO write enable).
REQ-011 SHALL have port: div0  output  1  one-cycle pulse coincident with done on divide by zero.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE.
REQ-013 Transitions SHALL be: IDLE->MULT on start&!op; IDLE->DIV on start&op; MULT/DIV->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-014 a, b and op SHALL be latched in the start cycle T; later input changes SHALL be ignored.
REQ-015 MULT SHALL use radix-2 Booth, one step per cycle, 64-bit two's-complement product.
REQ-016 DIV SHALL use restoring division on magnitudes, one quotient bit per cycle.
REQ-017 DIV quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-018 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no flag.
REQ-019 A 6-bit iteration counter SHALL count 0..31; done and busy=0 SHALL occur at T+33.
REQ-020 busy SHALL be high from T+1 through T+32 inclusive.
REQ-021 start asserted while not IDLE SHALL be ignored and SHALL not be queued.
REQ-022 hi/lo SHALL hold the last result until the next done; intermediate values SHALL not appear on hi/lo.

Reset
REQ-023 On reset=0: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div0=0.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-025 The macro MULT_DIV_DIV0_CHECK_EN SHALL control divide-by-zero handling.
REQ-026 With the macro defined: divide with b=0 SHALL go IDLE->DONE; done and div0 SHALL pulse at T+1; hi/lo SHALL be unchanged.
REQ-027 Without the macro: div0 SHALL be tied to 0 and b=0 SHALL run all 32 iterations.
REQ-028 In that no-check case the result SHALL be hi=a, lo=0xFFFFFFFF when a>=0, else lo=0x00000001.

Structure
REQ-029 Package mult_div_pkg SHALL hold the state enum, the OP_MULT/OP_DIV encodings and ITER_COUNT=32.
REQ-030 The block SHALL be one module with no sub-module; magnitude and sign-fixup logic SHALL be inline.

Verification
REQ-031 mult 7 x 0xFFFFFFFD at T -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at T+33, busy low at T+33.
REQ-032 mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 With MULT_DIV_DIV0_CHECK_EN, div 100 / 0 -> done=div0=1 at T+1, hi/lo keep prior values. Without it -> hi=100, lo=0xFFFFFFFF at T+33, div0 never high.
REQ-035 start pulse at T+5 during busy -> ignored, exactly one done. Then reset low at T+10 -> all outputs 0, no done. A new mult 3 x 4 -> lo=12, hi=0.
